vmem_arbiter: RTL and testbench

VMEM_ARBITER -- requirements
Module: vmem_arbiter

---
 rtl/vmem_pkg.sv | 18 +
 rtl/vmem_arbiter_if.sv | 12 +
 rtl/vmem_wr_fifo.sv | 52 +++++
 rtl/vmem_arbiter.sv | 125 ++++++++++++
 tb/tb_vmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_pkg.sv
// Shared widths, FIFO entry layout and clear-FSM state encoding for the
// video-memory arbiter.
package vmem_pkg;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 24;
  localparam int H_W    = 10;
  localparam int V_W    = 9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_entry_t;
endpackage

// File: rtl/vmem_arbiter_if.sv
// Pixel-write handshake channel into the arbiter: transfer when valid and ready.
interface vmem_arbiter_if;
  import vmem_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/vmem_wr_fifo.sv
// Synchronous pixel-write FIFO; pointers and level reset, storage does not.
module vmem_wr_fifo
  import vmem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  wr_entry_t        push_data,
  input  logic             pop,
  output wr_entry_t        pop_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  wr_entry_t        store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  assign pop_data = store[rd_ptr];
endmodule

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: display read beats screen clear beats
// buffered pixel writes, one memory access per cycle.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        disp_en,
  input  logic [H_W-1:0]              disp_h_addr,
  input  logic [V_W-1:0]              disp_v_addr,
  output logic [PIX_W-1:0]            disp_data,
  output logic                        disp_data_valid,
  vmem_arbiter_if.slave               wr,
  input  logic                        clr_req,
  input  logic [PIX_W-1:0]            clr_color,
  output logic                        clr_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [PIX_W-1:0]            mem_wdata,
  input  logic [PIX_W-1:0]            mem_rdata
);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_PIX - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_PIX - 1);

  state_t           state;
  logic [H_W-1:0]   clr_h;
  logic [V_W-1:0]   clr_v;
  logic [PIX_W-1:0] clr_color_q;
  logic             disp_vld_p1;
  wr_entry_t        push_entry;
  wr_entry_t        fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             clr_wr;

  assign push_entry = '{addr: wr.wr_addr, data: wr.wr_data};
  assign wr.wr_ready = !fifo_full;
  assign clr_wr     = (state == CLEAR) && !disp_en;
  // Buffered writes stay parked for the whole clear so they land on top of it.
  assign fifo_pop   = (state == IDLE) && !disp_en && !fifo_empty;
  assign clr_busy   = (state == CLEAR);

  vmem_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wr.wr_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_en) begin
      mem_addr = {disp_h_addr, disp_v_addr};
    end else if (clr_wr) begin
      mem_we    = 1'b1;
      mem_addr  = {clr_h, clr_v};
      mem_wdata = clr_color_q;
    end else if (fifo_pop) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_head.addr;
      mem_wdata = fifo_head.data;
    end
  end

  // Clear sweep: column-major, v fastest; a display stall holds the position.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      clr_h <= '0;
      clr_v <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            clr_h <= '0;
            clr_v <= '0;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_v == V_LAST) begin
              clr_v <= '0;
              if (clr_h == H_LAST) begin
                state <= IDLE;
                clr_h <= '0;
              end else begin
                clr_h <= clr_h + H_W'(1);
              end
            end else begin
              clr_v <= clr_v + V_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && clr_req) clr_color_q <= clr_color;
  end

  // p1: display read data returns one cycle after the address was issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) disp_vld_p1 <= 1'b0;
    else         disp_vld_p1 <= disp_en;
  end

  assign disp_data_valid = disp_vld_p1;
  assign disp_data       = disp_vld_p1 ? mem_rdata : '0;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter on a reduced 8x6 screen with a frame-buffer model.
module tb_vmem_arbiter;
  import vmem_pkg::*;

  localparam int DEPTH = 4;
  localparam int HP    = 8;
  localparam int VP    = 6;
  localparam int NPIX  = HP * VP;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             disp_en = 1'b0;
  logic [H_W-1:0]   disp_h = '0;
  logic [V_W-1:0]   disp_v = '0;
  logic [PIX_W-1:0] disp_data;
  logic             disp_data_valid;
  logic             clr_req = 1'b0;
  logic [PIX_W-1:0] clr_color = '0;
  logic             clr_busy;
  logic [2:0]       fifo_level;
  logic [ADDR_W-1:0] mem_addr;
  logic             mem_we;
  logic [PIX_W-1:0] mem_wdata;
  logic [PIX_W-1:0] mem_rdata = '0;

  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [PIX_W-1:0]  pre_data = '0;
  logic [PIX_W-1:0]  fbmem [0:(1<<ADDR_W)-1];

  logic [ADDR_W+PIX_W-1:0] wq [$];
  logic [ADDR_W-1:0]       cq [$];
  logic [PIX_W-1:0]        dq [$];
  logic [PIX_W-1:0]        ref_fb [int];
  logic [PIX_W-1:0]        ccolor_m = '0;
  logic [ADDR_W-1:0]       last_clr_addr = '0;
  logic                    busy_exp;
  logic                    ready_exp;

  int n_checks = 0;
  int n_fail = 0;
  int cnt;

  vmem_arbiter_if wr_if ();

  vmem_arbiter #(.FIFO_DEPTH(DEPTH), .H_PIX(HP), .V_PIX(VP)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .disp_en         (disp_en),
    .disp_h_addr     (disp_h),
    .disp_v_addr     (disp_v),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .wr              (wr_if),
    .clr_req         (clr_req),
    .clr_color       (clr_color),
    .clr_busy        (clr_busy),
    .fifo_level      (fifo_level),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // Frame-buffer memory: one-cycle synchronous read, write on mem_we.
  always @(posedge clk) begin
    mem_rdata <= fbmem[mem_addr];
    if (mem_we) fbmem[mem_addr] <= mem_wdata;
    else if (pre_we) fbmem[pre_addr] <= pre_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every cycle's outputs against the expectation queues.
  always @(negedge clk) begin
    if (resetn) begin
      busy_exp  = (cq.size() != 0);
      ready_exp = (wq.size() < DEPTH);
      chk("wr_ready", 64'(wr_if.wr_ready), 64'(ready_exp));
      chk("fifo_level", 64'(fifo_level), 64'(wq.size()));
      chk("clr_busy", 64'(clr_busy), 64'(busy_exp));
      chk("disp_valid", 64'(disp_data_valid), 64'(dq.size() != 0));
      if (dq.size() != 0) chk("disp_data", 64'(disp_data), 64'(dq.pop_front()));
      else chk("disp_data_idle", 64'(disp_data), 64'(0));
      chk("mem_we", 64'(mem_we), 64'(!disp_en && (busy_exp || wq.size() != 0)));
      if (disp_en) begin
        chk("disp_addr", 64'(mem_addr), 64'({disp_h, disp_v}));
      end else if (mem_we && busy_exp) begin
        chk("clr_addr", 64'(mem_addr), 64'(cq.pop_front()));
        chk("clr_data", 64'(mem_wdata), 64'(ccolor_m));
        last_clr_addr = mem_addr;
      end else if (mem_we && wq.size() != 0) begin
        chk("fifo_write", 64'({mem_addr, mem_wdata}), 64'(wq.pop_front()));
      end else begin
        chk("idle_addr", 64'(mem_addr), 64'(0));
        chk("idle_wdata", 64'(mem_wdata), 64'(0));
      end
      if (disp_en) dq.push_back(fbmem[{disp_h, disp_v}]);
      if (clr_req && !busy_exp) begin
        ccolor_m = clr_color;
        for (int h = 0; h < HP; h++)
          for (int v = 0; v < VP; v++) begin
            cq.push_back({H_W'(h), V_W'(v)});
            ref_fb[int'({H_W'(h), V_W'(v)})] = clr_color;
          end
      end
      if (wr_if.wr_valid && ready_exp) begin
        wq.push_back({wr_if.wr_addr, wr_if.wr_data});
        ref_fb[int'(wr_if.wr_addr)] = wr_if.wr_data;
      end
    end
  end

  task automatic run_clear(input bit toggle, input logic [PIX_W-1:0] color, output int n);
    bit en;
    n  = 0;
    en = 1'b1;
    cyc();
    disp_en   = 1'b0;
    clr_req   = 1'b1;
    clr_color = color;
    for (int i = 0; i < 4 * NPIX + 10; i++) begin
      @(negedge clk);
      if (clr_busy) n++;
      else if (n > 0) break;
      cyc();
      clr_req = 1'b0;
      if (toggle) begin
        disp_en = en;
        disp_h  = H_W'($urandom_range(0, 639));
        disp_v  = V_W'($urandom_range(0, 479));
        en      = !en;
      end
    end
    cyc();
    clr_req = 1'b0;
    disp_en = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    pre_we   = 1'b1;
    pre_addr = {H_W'(5), V_W'(7)};
    pre_data = 24'hABCDEF;
    repeat (2) @(posedge clk);
    #1;
    pre_we = 1'b0;
    chk("rst_busy", 64'(clr_busy), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_ready", 64'(wr_if.wr_ready), 64'(1));
    chk("rst_valid", 64'(disp_data_valid), 64'(0));
    chk("rst_data", 64'(disp_data), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    cyc();
    resetn = 1'b1;

    // Display read of a preloaded pixel.
    cyc();
    disp_en = 1'b1; disp_h = 10'd5; disp_v = 9'd7;
    #1;
    chk("rd_addr", 64'(mem_addr), 64'(19'h00A07));
    chk("rd_we", 64'(mem_we), 64'(0));
    cyc();
    disp_en = 1'b0;
    chk("rd_data", 64'(disp_data), 64'(24'hABCDEF));
    chk("rd_valid", 64'(disp_data_valid), 64'(1));

    // Fill the FIFO while the display hogs the memory.
    cyc();
    disp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = {H_W'(i), V_W'(1)};
      wr_if.wr_data  = PIX_W'($urandom);
    end
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_ready", 64'(wr_if.wr_ready), 64'(0));
    cyc();
    wr_if.wr_valid = 1'b0;
    disp_en = 1'b0;
    for (int i = 0; i < 20 && wq.size() != 0; i++) cyc();
    chk("drain_level", 64'(fifo_level), 64'(0));

    // Single write lands the cycle after acceptance.
    cyc();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = {H_W'(3), V_W'(2)};
    wr_if.wr_data  = 24'h123456;
    cyc();
    wr_if.wr_valid = 1'b0;
    chk("wr1_we", 64'(mem_we), 64'(1));
    chk("wr1_addr", 64'(mem_addr), 64'({H_W'(3), V_W'(2)}));
    chk("wr1_data", 64'(mem_wdata), 64'(24'h123456));
    cyc();
    chk("wr1_level", 64'(fifo_level), 64'(0));

    // Reset in the middle of a clear with two writes parked.
    cyc();
    clr_req = 1'b1; clr_color = 24'h00FF00;
    cyc();
    clr_req = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = {H_W'(2), V_W'(3)};
    wr_if.wr_data  = PIX_W'($urandom);
    cyc();
    wr_if.wr_addr  = {H_W'(4), V_W'(4)};
    cyc();
    wr_if.wr_valid = 1'b0;
    for (int i = 0; i < 200 && !(mem_we && mem_addr == {H_W'(1), V_W'(0)}); i++) cyc();
    chk("abort_at_addr", 64'(mem_addr), 64'({H_W'(1), V_W'(0)}));
    chk("abort_level", 64'(fifo_level), 64'(2));
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_busy", 64'(clr_busy), 64'(0));
    chk("abort_level0", 64'(fifo_level), 64'(0));
    chk("abort_ready", 64'(wr_if.wr_ready), 64'(1));
    chk("abort_we", 64'(mem_we), 64'(0));
    wq.delete();
    cq.delete();
    dq.delete();
    cyc();
    cyc();
    resetn = 1'b1;

    // Full clear, memory always free.
    run_clear(1'b0, 24'h0000FF, cnt);
    chk("clear_cycles", 64'(cnt), 64'(NPIX));
    chk("clear_last", 64'(last_clr_addr), 64'({H_W'(HP-1), V_W'(VP-1)}));

    // Full clear interleaved with display reads every other cycle.
    run_clear(1'b1, 24'hC0FFEE, cnt);
    chk("clear_tog_cycles", 64'(cnt), 64'(2 * NPIX));

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      cyc();
      disp_en        = ($urandom_range(0, 9) < 3);
      disp_h         = H_W'($urandom_range(0, 639));
      disp_v         = V_W'($urandom_range(0, 479));
      wr_if.wr_valid = 1'($urandom_range(0, 1));
      wr_if.wr_addr  = {H_W'($urandom_range(0, HP-1)), V_W'($urandom_range(0, VP-1))};
      wr_if.wr_data  = PIX_W'($urandom);
      clr_req        = ($urandom_range(0, 49) == 0) && (cq.size() != 0 || wq.size() == 0);
      clr_color      = PIX_W'($urandom);
    end
    cyc();
    disp_en = 1'b0;
    wr_if.wr_valid = 1'b0;
    clr_req = 1'b0;
    for (int i = 0; i < 500 && (wq.size() != 0 || cq.size() != 0); i++) cyc();
    cyc();
    cyc();
    chk("end_level", 64'(fifo_level), 64'(0));
    chk("end_busy", 64'(clr_busy), 64'(0));
    foreach (ref_fb[a]) chk("frame", 64'(fbmem[ADDR_W'(a)]), 64'(ref_fb[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
